// File: rtl/id_stage_pipe.sv
// RV32I(+M) instruction decode stage: decodes one instruction per cycle into a
// registered bundle for EX, with load-use interlock, valid/ready handshake and flush.
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_SYS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic            out_portb_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_byte,
  output logic            out_mem_half,
  output logic            out_mem_unsigned,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_syscall,
  output logic            out_break,
  output logic            out_mret,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRA   = 5'd6;
  localparam logic [4:0] ALU_SRL   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_MUL   = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd18;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SH
  } imm_fmt_e;

  // funct3 -> ALU op for the shared OP / OP-IMM encoding space (funct7 = 0)
  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic signed [XLEN-1:0] build_imm(input imm_fmt_e fmt,
                                                       input logic [31:0] w);
    case (fmt)
      IMM_I:   return {{(XLEN-12){w[31]}}, w[31:20]};
      IMM_S:   return {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   return {w[31:12], 12'h000};
      IMM_J:   return {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      IMM_SH:  return {{(XLEN-5){1'b0}}, w[24:20]};
      default: return '0;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_p0, rs2_p0, rd_p0;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rs1_p0 = in_inst[19:15];
  assign rs2_p0 = in_inst[24:20];
  assign rd_p0  = in_inst[11:7];

  imm_fmt_e                fmt_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic [4:0]              alu_p0;
  logic portb_p0, wr_p0, mrd_p0, mwr_p0, byte_p0, half_p0, uns_p0;
  logic br_p0, jal_p0, jalr_p0, sys_p0, brk_p0, mret_p0, bad_p0;

  // Stage p0: combinational decode of the instruction offered by IF
  always_comb begin
    fmt_p0   = IMM_NONE;
    alu_p0   = ALU_ADD;
    portb_p0 = 1'b0;
    wr_p0    = 1'b0;
    mrd_p0   = 1'b0;
    mwr_p0   = 1'b0;
    byte_p0  = 1'b0;
    half_p0  = 1'b0;
    uns_p0   = 1'b0;
    br_p0    = 1'b0;
    jal_p0   = 1'b0;
    jalr_p0  = 1'b0;
    sys_p0   = 1'b0;
    brk_p0   = 1'b0;
    mret_p0  = 1'b0;
    bad_p0   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        fmt_p0   = IMM_U;
        alu_p0   = ALU_PASSB;
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
      end
      OPC_AUIPC: begin
        fmt_p0   = IMM_U;
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
      end
      OPC_JAL: begin
        fmt_p0   = IMM_J;
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
        jal_p0   = 1'b1;
      end
      OPC_JALR: begin
        fmt_p0   = IMM_I;
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
        jalr_p0  = 1'b1;
        bad_p0   = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        fmt_p0 = IMM_B;
        alu_p0 = ALU_SUB;
        br_p0  = 1'b1;
        bad_p0 = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        fmt_p0   = IMM_I;
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
        mrd_p0   = 1'b1;
        byte_p0  = (funct3[1:0] == 2'd0);
        half_p0  = (funct3[1:0] == 2'd1);
        uns_p0   = funct3[2];
        bad_p0   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        fmt_p0   = IMM_S;
        portb_p0 = 1'b1;
        mwr_p0   = 1'b1;
        byte_p0  = (funct3 == 3'd0);
        half_p0  = (funct3 == 3'd1);
        bad_p0   = (funct3 > 3'd2);
      end
      OPC_OPIMM: begin
        portb_p0 = 1'b1;
        wr_p0    = 1'b1;
        if (funct3 == 3'd1) begin
          fmt_p0 = IMM_SH;
          alu_p0 = ALU_SLL;
          bad_p0 = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          fmt_p0 = IMM_SH;
          alu_p0 = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
          bad_p0 = (funct7 != 7'h00) && (funct7 != 7'h20);
        end else begin
          fmt_p0 = IMM_I;
          alu_p0 = alu_from_funct3(funct3);
        end
      end
      OPC_OP: begin
        wr_p0 = 1'b1;
        case (funct7)
          7'h00: alu_p0 = alu_from_funct3(funct3);
          7'h20: begin
            if (funct3 == 3'd0)      alu_p0 = ALU_SUB;
            else if (funct3 == 3'd5) alu_p0 = ALU_SRA;
            else                     bad_p0 = 1'b1;
          end
          7'h01: begin
            alu_p0 = ALU_MUL + {2'b00, funct3};
            bad_p0 = !ENABLE_M;
          end
          default: bad_p0 = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        fmt_p0 = IMM_I;
        if (!ENABLE_SYS) begin
          bad_p0 = 1'b1;
        end else if (funct3 == 3'd0) begin
          // Privileged forms are recognised only as exact words
          sys_p0  = (in_inst == INST_ECALL);
          brk_p0  = (in_inst == INST_EBREAK);
          mret_p0 = (in_inst == INST_MRET);
          bad_p0  = !(sys_p0 || brk_p0 || mret_p0);
        end else if (funct3 == 3'd4) begin
          bad_p0 = 1'b1;
        end else begin
          wr_p0 = 1'b1;
        end
      end
      default: bad_p0 = 1'b1;
    endcase

    if (bad_p0) begin
      fmt_p0   = IMM_NONE;
      alu_p0   = ALU_ADD;
      portb_p0 = 1'b0;
      wr_p0    = 1'b0;
      mrd_p0   = 1'b0;
      mwr_p0   = 1'b0;
      byte_p0  = 1'b0;
      half_p0  = 1'b0;
      uns_p0   = 1'b0;
      br_p0    = 1'b0;
      jal_p0   = 1'b0;
      jalr_p0  = 1'b0;
      sys_p0   = 1'b0;
      brk_p0   = 1'b0;
      mret_p0  = 1'b0;
    end
    if (rd_p0 == 5'd0) wr_p0 = 1'b0;
  end

  assign imm_p0 = build_imm(fmt_p0, in_inst);

  logic uses_rs1, uses_rs2, hazard, accept;

  assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign uses_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
  assign hazard   = ex_mem_read && (ex_rd != 5'd0) && in_valid &&
                    ((uses_rs1 && (rs1_p0 == ex_rd)) || (uses_rs2 && (rs2_p0 == ex_rd)));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Stage p1: ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      out_rs1          <= '0;
      out_rs2          <= '0;
      out_rd           <= '0;
      out_imm          <= '0;
      out_alu_op       <= '0;
      out_portb_imm    <= 1'b0;
      out_reg_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_mem_write    <= 1'b0;
      out_mem_byte     <= 1'b0;
      out_mem_half     <= 1'b0;
      out_mem_unsigned <= 1'b0;
      out_branch       <= 1'b0;
      out_jal          <= 1'b0;
      out_jalr         <= 1'b0;
      out_syscall      <= 1'b0;
      out_break        <= 1'b0;
      out_mret         <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      out_pc           <= in_pc;
      out_rs1          <= rs1_p0;
      out_rs2          <= rs2_p0;
      out_rd           <= rd_p0;
      out_imm          <= imm_p0;
      out_alu_op       <= alu_p0;
      out_portb_imm    <= portb_p0;
      out_reg_write    <= wr_p0;
      out_mem_read     <= mrd_p0;
      out_mem_write    <= mwr_p0;
      out_mem_byte     <= byte_p0;
      out_mem_half     <= half_p0;
      out_mem_unsigned <= uns_p0;
      out_branch       <= br_p0;
      out_jal          <= jal_p0;
      out_jalr         <= jalr_p0;
      out_syscall      <= sys_p0;
      out_break        <= brk_p0;
      out_mret         <= mret_p0;
      out_illegal      <= bad_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: two instances (M on / M off) share stimulus,
// expected bundles are queued at issue and popped by a monitor on the falling edge.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic portb_imm, reg_write, mem_read, mem_write, mem_byte, mem_half, mem_unsigned;
    logic branch, jal, jalr, syscall, brk, mret, illegal;
  } bundle_t;

  typedef struct {
    bundle_t em;
    bundle_t en;
    int      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, ex_mem_read, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  ex_rd;

  always #5 clk = ~clk;

  logic m_in_ready, m_out_valid, n_in_ready, n_out_valid;
  logic [31:0] m_pc, m_imm, n_pc, n_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_alu, n_rs1, n_rs2, n_rd, n_alu;
  logic m_pb, m_rw, m_mr, m_mw, m_mb, m_mh, m_mu, m_br, m_jal, m_jalr, m_sys, m_brk, m_mret, m_ill;
  logic n_pb, n_rw, n_mr, n_mw, n_mb, n_mh, n_mu, n_br, n_jal, n_jalr, n_sys, n_brk, n_mret, n_ill;
  bundle_t m_b, n_b;

  assign m_b = {m_pc, m_rs1, m_rs2, m_rd, m_imm, m_alu, m_pb, m_rw, m_mr, m_mw, m_mb, m_mh,
                m_mu, m_br, m_jal, m_jalr, m_sys, m_brk, m_mret, m_ill};
  assign n_b = {n_pc, n_rs1, n_rs2, n_rd, n_imm, n_alu, n_pb, n_rw, n_mr, n_mw, n_mb, n_mh,
                n_mu, n_br, n_jal, n_jalr, n_sys, n_brk, n_mret, n_ill};

  id_stage_pipe #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SYS(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_pc), .out_rs1(m_rs1),
    .out_rs2(m_rs2), .out_rd(m_rd), .out_imm(m_imm), .out_alu_op(m_alu),
    .out_portb_imm(m_pb), .out_reg_write(m_rw), .out_mem_read(m_mr), .out_mem_write(m_mw),
    .out_mem_byte(m_mb), .out_mem_half(m_mh), .out_mem_unsigned(m_mu), .out_branch(m_br),
    .out_jal(m_jal), .out_jalr(m_jalr), .out_syscall(m_sys), .out_break(m_brk),
    .out_mret(m_mret), .out_illegal(m_ill));

  id_stage_pipe #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYS(1'b1)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_pc), .out_rs1(n_rs1),
    .out_rs2(n_rs2), .out_rd(n_rd), .out_imm(n_imm), .out_alu_op(n_alu),
    .out_portb_imm(n_pb), .out_reg_write(n_rw), .out_mem_read(n_mr), .out_mem_write(n_mw),
    .out_mem_byte(n_mb), .out_mem_half(n_mh), .out_mem_unsigned(n_mu), .out_branch(n_br),
    .out_jal(n_jal), .out_jalr(n_jalr), .out_syscall(n_sys), .out_break(n_brk),
    .out_mret(n_mret), .out_illegal(n_ill));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Reference decoder: instruction semantics from the RV32I/M tables
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                         input bit en_m);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] f3_alu [8];
    logic [31:0] imm_i;
    bit bad;
    f3_alu = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd7, 5'd3, 5'd2};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    imm_i = {{20{w[31]}}, w[31:20]};
    b = '0;
    bad = 1'b0;
    case (op)
      7'h37: begin b.imm = {w[31:12], 12'h000}; b.alu_op = 5'd18; b.portb_imm = 1; b.reg_write = 1; end
      7'h17: begin b.imm = {w[31:12], 12'h000}; b.portb_imm = 1; b.reg_write = 1; end
      7'h6F: begin
        b.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        b.portb_imm = 1; b.reg_write = 1; b.jal = 1;
      end
      7'h67: begin b.imm = imm_i; b.portb_imm = 1; b.reg_write = 1; b.jalr = 1; bad = (f3 != 0); end
      7'h63: begin
        b.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        b.alu_op = 5'd1; b.branch = 1; bad = (f3 == 2 || f3 == 3);
      end
      7'h03: begin
        b.imm = imm_i; b.portb_imm = 1; b.reg_write = 1; b.mem_read = 1;
        b.mem_byte = (f3 == 0 || f3 == 4); b.mem_half = (f3 == 1 || f3 == 5);
        b.mem_unsigned = (f3 == 4 || f3 == 5);
        bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        b.imm = {{20{w[31]}}, w[31:25], w[11:7]}; b.portb_imm = 1; b.mem_write = 1;
        b.mem_byte = (f3 == 0); b.mem_half = (f3 == 1); bad = (f3 > 2);
      end
      7'h13: begin
        b.portb_imm = 1; b.reg_write = 1;
        if (f3 == 1)      begin b.imm = {27'd0, w[24:20]}; b.alu_op = 5'd5; bad = (f7 != 0); end
        else if (f3 == 5) begin
          b.imm = {27'd0, w[24:20]};
          b.alu_op = (f7 == 7'h20) ? 5'd6 : 5'd7;
          bad = !(f7 == 7'h00 || f7 == 7'h20);
        end else begin b.imm = imm_i; b.alu_op = f3_alu[f3]; end
      end
      7'h33: begin
        b.reg_write = 1;
        if (f7 == 7'h00) b.alu_op = f3_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) b.alu_op = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) b.alu_op = 5'd6;
        else if (f7 == 7'h01 && en_m) b.alu_op = 5'd10 + 5'(f3);
        else bad = 1'b1;
      end
      7'h73: begin
        b.imm = imm_i;
        if (w == 32'h0000_0073)      b.syscall = 1;
        else if (w == 32'h0010_0073) b.brk = 1;
        else if (w == 32'h3020_0073) b.mret = 1;
        else if (f3 == 0 || f3 == 4) bad = 1'b1;
        else b.reg_write = 1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      b = '0;
      b.illegal = 1'b1;
    end
    b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
    if (b.rd == 0) b.reg_write = 1'b0;
    return b;
  endfunction

  function automatic bit ref_hazard(input logic v, input logic [31:0] w, input logic emr,
                                    input logic [4:0] erd);
    bit r1, r2;
    r1 = !(w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h6F);
    r2 = (w[6:0] == 7'h63 || w[6:0] == 7'h23 || w[6:0] == 7'h33);
    return v && emr && erd != 0 && ((r1 && w[19:15] == erd) || (r2 && w[24:20] == erd));
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [10];
    logic [6:0] f7s [4];
    logic [31:0] sys [5];
    int sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
    sys = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h0000_0013, 32'h0};
    sel = $urandom_range(0, 7);
    if (sel == 0) return $urandom;
    if (sel == 7) return sys[$urandom_range(0, 4)];
    return {f7s[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic fl, input logic emr,
                       input logic [4:0] erd, input logic ordy);
    bit ev, acc;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v; in_inst = w; flush = fl; ex_mem_read = emr; ex_rd = erd; out_ready = ordy;
    in_pc = $urandom & 32'hFFFF_FFFC;
    ev = (q.size() > 0) && (q[0].cyc < cyc);
    acc = v && (!ev || ordy) && !ref_hazard(v, w, emr, erd) && !fl;
    if (acc) begin
      e.em = ref_decode(w, in_pc, 1'b1);
      e.en = ref_decode(w, in_pc, 1'b0);
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit ev, er;
    if (mon_en) begin
      ev = (q.size() > 0) && (q[0].cyc < cyc);
      er = (!ev || out_ready) && !ref_hazard(in_valid, in_inst, ex_mem_read, ex_rd) && !flush;
      check("out_valid_m", 128'(m_out_valid), 128'(ev));
      check("out_valid_nm", 128'(n_out_valid), 128'(ev));
      check("in_ready_m", 128'(m_in_ready), 128'(er));
      check("in_ready_nm", 128'(n_in_ready), 128'(er));
      if (ev) begin
        if (m_out_valid) check("bundle_m", 128'(m_b), 128'(q[0].em));
        if (n_out_valid) check("bundle_nm", 128'(n_b), 128'(q[0].en));
        if (flush || out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0;
    ex_mem_read = 0; ex_rd = 0; out_ready = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_m", 128'({m_out_valid, m_b}), 128'(0));
    check("reset_nm", 128'({n_out_valid, n_b}), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;

    drive(1, 32'h0050_0093, 0, 0, 0, 1);
    drive(1, 32'h1234_52B7, 0, 0, 0, 1);
    check("addi_fields", 128'({m_out_valid, m_rd, m_imm, m_alu, m_pb, m_rw}),
          128'({1'b1, 5'd1, 32'd5, 5'd0, 1'b1, 1'b1}));
    drive(1, 32'hFE00_0EE3, 0, 0, 0, 1);
    check("lui_fields", 128'({m_imm, m_alu, m_rd}), 128'({32'h1234_5000, 5'd18, 5'd5}));
    drive(1, 32'h0011_01B3, 0, 1, 5'd2, 1);
    check("beq_fields", 128'({m_imm, m_br, m_alu, m_rw}), 128'({32'hFFFF_FFFC, 1'b1, 5'd1, 1'b0}));
    #1 check("hazard_in_ready", 128'(m_in_ready), 128'(0));
    drive(1, 32'h0011_01B3, 0, 0, 0, 1);
    check("hazard_bubble", 128'(m_out_valid), 128'(0));
    drive(1, 32'h0220_81B3, 0, 0, 0, 1);
    check("add_after_hazard", 128'({m_out_valid, m_alu, m_rd}), 128'({1'b1, 5'd0, 5'd3}));
    drive(1, 32'h00A0_0113, 0, 0, 0, 0);
    check("mul_m", 128'({m_alu, m_ill}), 128'({5'd10, 1'b0}));
    check("mul_nm", 128'({n_ill, n_rw, n_alu}), 128'({1'b1, 1'b0, 5'd0}));
    drive(1, 32'h00A0_0113, 0, 0, 0, 0);
    drive(1, 32'h00A0_0113, 0, 0, 0, 0);
    #1 check("backpressure_in_ready", 128'(m_in_ready), 128'(0));
    check("backpressure_hold", 128'({m_out_valid, m_alu}), 128'({1'b1, 5'd10}));
    drive(1, 32'h00A0_0113, 1, 0, 0, 0);
    drive(1, 32'h00A0_0113, 0, 0, 0, 1);
    check("flush_kills", 128'(m_out_valid), 128'(0));

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    repeat (3) drive(0, 32'h0, 0, 0, 0, 1);
    check("queue_drained", 128'(q.size()), 128'(0));

    drive(1, 32'h0050_0093, 0, 0, 0, 1);
    drive(1, 32'h1234_52B7, 0, 0, 0, 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset_m", 128'({m_out_valid, m_b}), 128'(0));
    check("async_reset_nm", 128'({n_out_valid, n_b}), 128'(0));
    q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
